// File: rtl/sl_pkg.sv
// rtl/sl_pkg.sv - SL transmitter config layout, timing limits and FSM states
package sl_pkg;

  localparam int MODE_MSB = 9;
  localparam int MODE_LSB = 7;
  localparam int LEN_MSB  = 5;

  localparam int MAX_MODE = 5;
  localparam int MIN_LEN  = 8;
  localparam int MAX_LEN  = 32;

  // Wide enough for the longest half-bit (2 << MAX_MODE = 64 clocks)
  localparam int HALF_W = 7;

  localparam logic [9:0] RESET_CFG = {3'd0, 1'b0, 6'd32};

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } sl_state_e;

  function automatic logic cfg_legal(input logic [9:0] cfg);
    logic [2:0] mode;
    logic [5:0] len;
    mode = cfg[MODE_MSB:MODE_LSB];
    len  = cfg[LEN_MSB:0];
    return (int'(mode) <= MAX_MODE) && (int'(len) >= MIN_LEN) &&
           (int'(len) <= MAX_LEN) && !len[0];
  endfunction

endpackage

// File: rtl/sl_bit_timer.sv
// rtl/sl_bit_timer.sv - half-bit phase timer, strikes every 2<<mode clocks while enabled
module sl_bit_timer
  import sl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [2:0] mode_i,
  output logic       strike_o
);

  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic [HALF_W-1:0] half;

  assign half     = HALF_W'(2) << mode_i;
  assign strike_o = en_i && (cnt_q == half - HALF_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || strike_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + HALF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sl_transmitter.sv
// rtl/sl_transmitter.sv - SL0/SL1 serial word transmitter with odd parity and stop condition
module sl_transmitter
  import sl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        SL0,
  output logic        SL1,
  input  logic [31:0] data_a,
  input  logic        send_imm,
  input  logic [9:0]  wr_config_w,
  input  logic        wr_config_enable,
  output logic [9:0]  r_config_w,
  output logic        send_in_process,
  output logic        status_changed
);

  sl_state_e   state_q, state_d;
  logic        phase_q, phase_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] shreg_q, shreg_d;
  logic        par_q, par_d;
  logic [9:0]  cfg_q, cfg_d;
  logic        sl0_q, sl0_d;
  logic        sl1_q, sl1_d;
  logic        busy_q, busy_d;
  logic        chg_q, chg_d;
  logic        strike;
  logic [5:0]  cfg_len;
  logic [31:0] aligned_word;

  sl_bit_timer u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (busy_q),
    .mode_i   (cfg_q[MODE_MSB:MODE_LSB]),
    .strike_o (strike)
  );

  // Left-justify the word so the MSB to send is always shreg[31]; unused bits fall off
  assign cfg_len      = cfg_q[LEN_MSB:0];
  assign aligned_word = data_a << (6'd32 - cfg_len);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    cfg_d     = cfg_q;

    case (state_q)
      IDLE: begin
        if (send_imm) begin
          state_d   = DATA;
          phase_d   = 1'b0;
          shreg_d   = aligned_word;
          bit_cnt_d = cfg_len - 6'd1;
          par_d     = ~^aligned_word;
        end else if (wr_config_enable && cfg_legal(wr_config_w)) begin
          cfg_d = {wr_config_w[MODE_MSB:MODE_LSB], 1'b0, wr_config_w[LEN_MSB:0]};
        end
      end
      DATA: begin
        if (strike) begin
          phase_d = ~phase_q;
          if (phase_q) begin
            if (bit_cnt_q == 6'd0) begin
              state_d = PARITY;
            end else begin
              bit_cnt_d = bit_cnt_q - 6'd1;
              shreg_d   = {shreg_q[30:0], 1'b0};
            end
          end
        end
      end
      PARITY: begin
        if (strike) begin
          phase_d = ~phase_q;
          if (phase_q) state_d = STOP;
        end
      end
      STOP: begin
        if (strike) begin
          phase_d = ~phase_q;
          if (phase_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line levels come from the next state so the pins are plain flops
    sl0_d = 1'b1;
    sl1_d = 1'b1;
    if (!phase_d) begin
      case (state_d)
        DATA: begin
          if (shreg_d[31]) sl1_d = 1'b0;
          else             sl0_d = 1'b0;
        end
        PARITY: begin
          if (par_d) sl1_d = 1'b0;
          else       sl0_d = 1'b0;
        end
        STOP: begin
          sl0_d = 1'b0;
          sl1_d = 1'b0;
        end
        default: ;
      endcase
    end

    busy_d = (state_d != IDLE);
    chg_d  = busy_d ^ busy_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= 1'b0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      cfg_q     <= RESET_CFG;
      sl0_q     <= 1'b1;
      sl1_q     <= 1'b1;
      busy_q    <= 1'b0;
      chg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      cfg_q     <= cfg_d;
      sl0_q     <= sl0_d;
      sl1_q     <= sl1_d;
      busy_q    <= busy_d;
      chg_q     <= chg_d;
    end
  end

  assign SL0             = sl0_q;
  assign SL1             = sl1_q;
  assign r_config_w      = cfg_q;
  assign send_in_process = busy_q;
  assign status_changed  = chg_q;

endmodule

// File: tb/tb_sl_transmitter.sv
// tb/tb_sl_transmitter.sv - self-checking bench for sl_transmitter with an SL pulse receiver
module tb_sl_transmitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SL0, SL1;
  logic [31:0] data_a = '0;
  logic        send_imm = 1'b0;
  logic [9:0]  wr_config_w = '0;
  logic        wr_config_enable = 1'b0;
  logic [9:0]  r_config_w;
  logic        send_in_process;
  logic        status_changed;

  int checks = 0;
  int errors = 0;

  sl_transmitter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .SL0              (SL0),
    .SL1              (SL1),
    .data_a           (data_a),
    .send_imm         (send_imm),
    .wr_config_w      (wr_config_w),
    .wr_config_enable (wr_config_enable),
    .r_config_w       (r_config_w),
    .send_in_process  (send_in_process),
    .status_changed   (status_changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // status_changed must be high exactly in the cycles where send_in_process toggled
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = send_in_process;
    end else begin
      chk("status_changed", {63'd0, status_changed}, {63'd0, send_in_process != prev_busy});
      prev_busy = send_in_process;
    end
  end

  typedef struct {
    logic [9:0] wr;
    logic [9:0] exp_rd;
  } cfg_vec_t;

  typedef struct {
    int          mode;
    int          len;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_par;
  } word_vec_t;

  cfg_vec_t  cfg_tab[8];
  word_vec_t word_tab[5];

  task automatic do_config(input logic [9:0] w);
    @(negedge clk);
    wr_config_w      = w;
    wr_config_enable = 1'b1;
    @(negedge clk);
    wr_config_enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_check(input logic [31:0] d, input int len, input int mode,
                            input logic [31:0] exp_d, input logic exp_par,
                            input bit inject, input bit col, input string tag);
    logic [1:0]  rv[$];
    int          rl[$];
    bit          bits[$];
    logic [1:0]  pair;
    logic [63:0] acc;
    int          cyc, h, nruns, nb;
    bit          timing_ok, stop_ok, par_bit, pvalid;

    @(negedge clk);
    data_a   = d;
    send_imm = 1'b1;
    if (col) begin
      wr_config_w      = 10'h088;
      wr_config_enable = 1'b1;
    end
    @(negedge clk);
    send_imm         = 1'b0;
    wr_config_enable = 1'b0;
    data_a           = $urandom;
    chk($sformatf("%s accepted", tag), {63'd0, send_in_process}, 64'd1);

    cyc = 0;
    while (send_in_process) begin
      pair = {SL0, SL1};
      if (rv.size() > 0 && rv[rv.size()-1] == pair) rl[rl.size()-1] = rl[rl.size()-1] + 1;
      else begin
        rv.push_back(pair);
        rl.push_back(1);
      end
      cyc++;
      if (inject) begin
        wr_config_w      = 10'h008;
        wr_config_enable = (cyc == 7);
        send_imm         = (cyc == 9);
        data_a           = $urandom;
      end
      if (cyc > 20000) begin
        chk($sformatf("%s timeout", tag), 64'd1, 64'd0);
        break;
      end
      @(negedge clk);
    end
    send_imm         = 1'b0;
    wr_config_enable = 1'b0;
    chk($sformatf("%s idle lines", tag), {62'd0, SL0, SL1}, 64'd3);

    h = 2 << mode;
    nruns = rv.size();
    chk($sformatf("%s busy cycles", tag), 64'(cyc), 64'((len + 2) * 2 * h));

    timing_ok = (nruns == 2 * (len + 2));
    for (int i = 0; i < nruns; i++) begin
      if (rl[i] != h) timing_ok = 0;
      if ((i % 2) == 1 && rv[i] != 2'b11) timing_ok = 0;
      if ((i % 2) == 0 && rv[i] == 2'b11) timing_ok = 0;
    end
    chk($sformatf("%s timing", tag), {63'd0, timing_ok}, 64'd1);

    stop_ok = 0;
    for (int i = 0; i < nruns; i += 2) begin
      if (rv[i] == 2'b00) begin
        stop_ok = (i == nruns - 2);
        break;
      end
      bits.push_back(rv[i] == 2'b10);
    end
    chk($sformatf("%s stop", tag), {63'd0, stop_ok}, 64'd1);

    nb = bits.size();
    acc = '0;
    par_bit = 0;
    for (int i = 0; i < nb - 1; i++) acc = {acc[62:0], bits[i]};
    if (nb > 0) par_bit = bits[nb-1];
    pvalid = (($countones(acc) + int'(par_bit)) % 2) == 1;
    chk($sformatf("%s dataOut", tag), acc, {32'd0, exp_d});
    chk($sformatf("%s bitCount", tag), 64'(nb - 1), 64'(len));
    chk($sformatf("%s parity bit", tag), {63'd0, par_bit}, {63'd0, exp_par});
    chk($sformatf("%s parityValid", tag), {63'd0, pvalid}, 64'd1);
  endtask

  initial begin
    logic [31:0] rd, md;
    int          rmode, rlen;
    logic [9:0]  rcfg;

    cfg_tab[0] = '{10'h008, 10'h008};
    cfg_tab[1] = '{10'h007, 10'h008};
    cfg_tab[2] = '{10'h308, 10'h008};
    cfg_tab[3] = '{10'h2A0, 10'h2A0};
    cfg_tab[4] = '{10'h022, 10'h2A0};
    cfg_tab[5] = '{10'h006, 10'h2A0};
    cfg_tab[6] = '{10'h190, 10'h190};
    cfg_tab[7] = '{10'h000, 10'h190};

    word_tab[0] = '{0, 8,  32'h0000_00A5, 32'h0000_00A5, 1'b1};
    word_tab[1] = '{2, 32, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
    word_tab[2] = '{4, 10, 32'h0000_02AB, 32'h0000_02AB, 1'b1};
    word_tab[3] = '{1, 8,  32'h0000_0001, 32'h0000_0001, 1'b0};
    word_tab[4] = '{3, 12, 32'hFFFF_F7FF, 32'h0000_07FF, 1'b0};

    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    chk("reset SL0", {63'd0, SL0}, 64'd1);
    chk("reset SL1", {63'd0, SL1}, 64'd1);
    chk("reset busy", {63'd0, send_in_process}, 64'd0);
    chk("reset status_changed", {63'd0, status_changed}, 64'd0);
    chk("reset config", {54'd0, r_config_w}, 64'h020);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_config(cfg_tab[i].wr);
      chk($sformatf("cfg[%0d]", i), {54'd0, r_config_w}, {54'd0, cfg_tab[i].exp_rd});
    end

    for (int i = 0; i < 5; i++) begin
      rcfg = {3'(word_tab[i].mode), 1'b0, 6'(word_tab[i].len)};
      do_config(rcfg);
      chk($sformatf("word[%0d] cfg", i), {54'd0, r_config_w}, {54'd0, rcfg});
      send_check(word_tab[i].data, word_tab[i].len, word_tab[i].mode,
                 word_tab[i].exp_data, word_tab[i].exp_par, 0, 0, $sformatf("word[%0d]", i));
    end

    for (int i = 0; i < 6; i++) begin
      rmode = $urandom_range(0, 5);
      rlen  = 2 * $urandom_range(4, 16);
      rd    = $urandom;
      md    = (rlen == 32) ? rd : (rd & ((32'd1 << rlen) - 32'd1));
      rcfg  = {3'(rmode), 1'b0, 6'(rlen)};
      do_config(rcfg);
      chk($sformatf("rand[%0d] cfg", i), {54'd0, r_config_w}, {54'd0, rcfg});
      send_check(rd, rlen, rmode, md, ($countones(md) % 2) == 0, 0, 0, $sformatf("rand[%0d]", i));
    end

    do_config(10'h090);
    send_check(32'h1234_C3A5, 16, 1, 32'h0000_C3A5, 1'b1, 1, 0, "midword");
    chk("midword cfg kept", {54'd0, r_config_w}, 64'h090);

    send_check(32'h0000_00F1, 16, 1, 32'h0000_00F1, 1'b0, 0, 1, "collide");
    repeat (2) @(negedge clk);
    chk("collide cfg dropped", {54'd0, r_config_w}, 64'h090);

    @(negedge clk);
    data_a   = 32'hFFFF_FFFF;
    send_imm = 1'b1;
    @(negedge clk);
    send_imm = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort SL0", {63'd0, SL0}, 64'd1);
    chk("abort SL1", {63'd0, SL1}, 64'd1);
    chk("abort busy", {63'd0, send_in_process}, 64'd0);
    chk("abort config", {54'd0, r_config_w}, 64'h020);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("after abort busy", {63'd0, send_in_process}, 64'd0);
    chk("after abort lines", {62'd0, SL0, SL1}, 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
